// File: rtl/pulse_sync_pkg.sv
// Shared constants for the multi-channel pulse synchroniser.
// Event counters are built only when PULSE_SYNC_CNT_EN is defined.
package pulse_sync_pkg;
  localparam int PS_MODE_BOTH = 0;
  localparam int PS_MODE_RISE = 1;
  localparam int PS_MODE_FALL = 2;
  localparam int PS_STR_W     = 8;
  localparam int PS_EVT_W     = 16;
endpackage

// File: rtl/pulse_sync_ch.sv
// One channel: synchroniser chain, edge detect, pulse stretcher, sticky overrun.
// PULSE_SYNC_CNT_EN adds a saturating per-channel event counter.
module pulse_sync_ch
  import pulse_sync_pkg::*;
#(
  parameter int P_SYNC    = 3,
  parameter int P_MODE    = PS_MODE_BOTH,
  parameter int P_STRETCH = 1
) (
  input  logic CLK,
  input  logic XRST,
  input  logic TOG_I,
  input  logic OVR_CLR_I,
  output logic PULSE_O,
  output logic BUSY_O,
  output logic OVR_O
`ifdef PULSE_SYNC_CNT_EN
  ,
  output logic [PS_EVT_W-1:0] EVT_CNT_O
`endif
);

  if (P_SYNC < 2) begin : g_bad_sync
    $error("pulse_sync_ch: P_SYNC must be at least 2");
  end
  if (P_STRETCH < 1 || P_STRETCH > 255) begin : g_bad_stretch
    $error("pulse_sync_ch: P_STRETCH must be 1..255");
  end

  localparam logic [PS_STR_W-1:0] RELOAD = PS_STR_W'(P_STRETCH - 1);

  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [P_SYNC-1:0] sync;
  logic                hist;
  logic                last;
  logic                det;
  logic [PS_STR_W-1:0] cnt;

  assign last = sync[P_SYNC-1];

  always_comb begin
    case (P_MODE)
      PS_MODE_RISE: det = last & ~hist;
      PS_MODE_FALL: det = ~last & hist;
      default:      det = last ^ hist;
    endcase
  end

  always_ff @(posedge CLK or posedge XRST) begin
    if (XRST) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[P_SYNC-2:0], TOG_I};
      hist <= last;
    end
  end

  // A detection while still high reloads the count, merging events into one pulse.
  always_ff @(posedge CLK or posedge XRST) begin
    if (XRST) begin
      cnt     <= '0;
      PULSE_O <= 1'b0;
      OVR_O   <= 1'b0;
    end else begin
      if (det) begin
        PULSE_O <= 1'b1;
        cnt     <= RELOAD;
      end else if (PULSE_O) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else           PULSE_O <= 1'b0;
      end
      if (det && PULSE_O) OVR_O <= 1'b1;
      else if (OVR_CLR_I) OVR_O <= 1'b0;
    end
  end

  assign BUSY_O = PULSE_O;

`ifdef PULSE_SYNC_CNT_EN
  always_ff @(posedge CLK or posedge XRST) begin
    if (XRST)                          EVT_CNT_O <= '0;
    else if (OVR_CLR_I)                EVT_CNT_O <= {{(PS_EVT_W-1){1'b0}}, det};
    else if (det && EVT_CNT_O != '1)   EVT_CNT_O <= EVT_CNT_O + 1'b1;
  end
`endif

endmodule

// File: rtl/pulse_sync_multi.sv
// P_CH independent event synchronisers into the CLK domain; the top only slices buses.
// Optional EVT_CNT_O port exists when PULSE_SYNC_CNT_EN is defined.
module pulse_sync_multi
  import pulse_sync_pkg::*;
#(
  parameter int P_CH      = 4,
  parameter int P_SYNC    = 3,
  parameter int P_MODE    = PS_MODE_BOTH,
  parameter int P_STRETCH = 1
) (
  input  logic            CLK,
  input  logic            XRST,
  input  logic [P_CH-1:0] TOG_I,
  input  logic [P_CH-1:0] OVR_CLR_I,
  output logic [P_CH-1:0] PULSE_O,
  output logic [P_CH-1:0] BUSY_O,
  output logic [P_CH-1:0] OVR_O
`ifdef PULSE_SYNC_CNT_EN
  ,
  output logic [P_CH*PS_EVT_W-1:0] EVT_CNT_O
`endif
);

  for (genvar n = 0; n < P_CH; n++) begin : g_ch
    pulse_sync_ch #(
      .P_SYNC    (P_SYNC),
      .P_MODE    (P_MODE),
      .P_STRETCH (P_STRETCH)
    ) u_ch (
      .CLK       (CLK),
      .XRST      (XRST),
      .TOG_I     (TOG_I[n]),
      .OVR_CLR_I (OVR_CLR_I[n]),
      .PULSE_O   (PULSE_O[n]),
      .BUSY_O    (BUSY_O[n]),
      .OVR_O     (OVR_O[n])
`ifdef PULSE_SYNC_CNT_EN
      ,
      .EVT_CNT_O (EVT_CNT_O[n*PS_EVT_W +: PS_EVT_W])
`endif
    );
  end

endmodule
